// File: rtl/syn_fc_engine.sv
// Fully-connected layer engine: LANES-wide signed MAC over IN_LEN inputs per
// neuron, bias add, arithmetic requantise, saturate. Optional ReLU via FC_RELU_EN.
module syn_fc_engine #(
  parameter int DW          = 8,
  parameter int LANES       = 8,
  parameter int IN_LEN      = 200,
  parameter int NEU_NUM     = 16,
  parameter int AW          = 24,
  parameter int SHIFT       = 7,
  parameter int WEIGHT_BASE = 0,
  localparam int BEATS      = IN_LEN / LANES,
  localparam int DAW        = (BEATS > 1) ? $clog2(BEATS) : 1,
  localparam int NAW        = (NEU_NUM > 1) ? $clog2(NEU_NUM) : 1,
  localparam int WDEPTH     = WEIGHT_BASE + NEU_NUM * BEATS,
  localparam int WAW        = (WDEPTH > 1) ? $clog2(WDEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_valid,
  output logic                  start_ready,
  output logic [DAW-1:0]        data_addr,
  input  logic [LANES*DW-1:0]   data_rd,
  output logic [WAW-1:0]        weight_addr,
  input  logic [LANES*DW-1:0]   weight_rd,
  output logic [NAW-1:0]        bias_addr,
  input  logic [DW-1:0]         bias_data,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DW-1:0]         res_data,
  output logic [NAW-1:0]        res_idx,
  output logic                  done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MAC,
    S_DRAIN,
    S_BIAS,
    S_OUT
  } state_t;

  localparam logic [DAW-1:0] KLAST = DAW'(BEATS - 1);
  localparam logic [NAW-1:0] NLAST = NAW'(NEU_NUM - 1);

  state_t                state_q, state_d;
  logic [NAW-1:0]        n_q, n_d;
  logic [DAW-1:0]        k_q, k_d;
  logic signed [AW-1:0]  acc_q, acc_d;
  logic [DW-1:0]         res_q, res_d;
  logic                  done_q, done_d;

  logic signed [AW-1:0]   dot;
  logic signed [DW-1:0]   lane_a, lane_b;
  logic signed [2*DW-1:0] prod;
  logic signed [AW-1:0]   prod_x;

  always_comb begin
    dot    = '0;
    lane_a = '0;
    lane_b = '0;
    prod   = '0;
    prod_x = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_a = data_rd[i*DW +: DW];
      lane_b = weight_rd[i*DW +: DW];
      prod   = lane_a * lane_b;
      prod_x = prod;
      dot    = dot + prod_x;
    end
  end

  logic signed [AW-1:0] bias_x, biased, shifted;
  logic [DW-1:0]        sat;

  always_comb begin
    bias_x  = $signed(bias_data);
    biased  = acc_q + bias_x;
    shifted = biased >>> SHIFT;
`ifdef FC_RELU_EN
    if (shifted[AW-1]) shifted = '0;
`endif
    // In range iff every bit above the DW-1 sign bit matches it
    if (shifted[AW-1:DW-1] == {(AW-DW+1){shifted[AW-1]}})
      sat = shifted[DW-1:0];
    else if (shifted[AW-1])
      sat = {1'b1, {(DW-1){1'b0}}};
    else
      sat = {1'b0, {(DW-1){1'b1}}};
  end

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    k_d     = k_q;
    acc_d   = acc_q;
    res_d   = res_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_valid) begin
          state_d = S_MAC;
          n_d     = '0;
          k_d     = '0;
          acc_d   = '0;
        end
      end
      S_MAC: begin
        // Read data for beat k-1 lands this cycle
        if (k_q != '0) acc_d = acc_q + dot;
        if (k_q == KLAST) begin
          k_d     = '0;
          state_d = S_DRAIN;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      S_DRAIN: begin
        acc_d   = acc_q + dot;
        state_d = S_BIAS;
      end
      S_BIAS: begin
        res_d   = sat;
        state_d = S_OUT;
      end
      S_OUT: begin
        if (res_ready) begin
          if (n_q == NLAST) begin
            done_d  = 1'b1;
            n_d     = '0;
            state_d = S_IDLE;
          end else begin
            n_d     = n_q + 1'b1;
            k_d     = '0;
            acc_d   = '0;
            state_d = S_MAC;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      k_q     <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      done_q  <= done_d;
    end
  end

  logic in_mac;
  assign in_mac      = (state_q == S_MAC);
  assign start_ready = (state_q == S_IDLE);
  assign res_valid   = (state_q == S_OUT);
  assign res_data    = res_q;
  assign res_idx     = n_q;
  assign bias_addr   = n_q;
  assign done        = done_q;
  assign data_addr   = in_mac ? k_q : '0;
  assign weight_addr = in_mac
    ? WAW'(WEIGHT_BASE + int'(n_q) * BEATS + int'(k_q))
    : '0;

endmodule

// File: tb/tb_syn_fc_engine.sv
// Scoreboard bench for syn_fc_engine: random and directed runs checked
// against an arithmetic reference model of the layer.
module tb_syn_fc_engine;

  localparam int DW      = 8;
  localparam int LANES   = 2;
  localparam int IN_LEN  = 6;
  localparam int NEU_NUM = 3;
  localparam int AW      = 20;
  localparam int SHIFT   = 2;
  localparam int WB      = 2;
  localparam int BEATS   = IN_LEN / LANES;
  localparam int DAW     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int NAW     = (NEU_NUM > 1) ? $clog2(NEU_NUM) : 1;
  localparam int WDEPTH  = WB + NEU_NUM * BEATS;
  localparam int WAW     = (WDEPTH > 1) ? $clog2(WDEPTH) : 1;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                start_valid = 1'b0;
  logic                start_ready;
  logic [DAW-1:0]      data_addr;
  logic [LANES*DW-1:0] data_rd = '0;
  logic [WAW-1:0]      weight_addr;
  logic [LANES*DW-1:0] weight_rd = '0;
  logic [NAW-1:0]      bias_addr;
  logic [DW-1:0]       bias_data = '0;
  logic                res_valid;
  logic                res_ready = 1'b1;
  logic [DW-1:0]       res_data;
  logic [NAW-1:0]      res_idx;
  logic                done;

  syn_fc_engine #(
    .DW(DW), .LANES(LANES), .IN_LEN(IN_LEN), .NEU_NUM(NEU_NUM),
    .AW(AW), .SHIFT(SHIFT), .WEIGHT_BASE(WB)
  ) dut (
    .clk(clk), .rst(rst),
    .start_valid(start_valid), .start_ready(start_ready),
    .data_addr(data_addr), .data_rd(data_rd),
    .weight_addr(weight_addr), .weight_rd(weight_rd),
    .bias_addr(bias_addr), .bias_data(bias_data),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_idx(res_idx), .done(done)
  );

  always #5 clk = ~clk;

  logic [LANES*DW-1:0] dmem [2**DAW];
  logic [LANES*DW-1:0] wmem [2**WAW];
  logic [DW-1:0]       bmem [2**NAW];

  always @(posedge clk) begin
    data_rd   <= dmem[data_addr];
    weight_rd <= wmem[weight_addr];
    bias_data <= bmem[bias_addr];
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic longint wrap(longint x);
    return (x <<< (64 - AW)) >>> (64 - AW);
  endfunction

  function automatic int model(int n);
    longint acc;
    longint s;
    int lo;
    int hi;
    logic signed [DW-1:0] dv, wv, bv;
    acc = 0;
    lo = -(1 << (DW - 1));
    hi = (1 << (DW - 1)) - 1;
    for (int k = 0; k < BEATS; k++)
      for (int l = 0; l < LANES; l++) begin
        dv = dmem[k][l*DW +: DW];
        wv = wmem[WB + n*BEATS + k][l*DW +: DW];
        acc = acc + longint'(dv) * longint'(wv);
      end
    acc = wrap(acc);
    bv = bmem[n];
    s = wrap(acc + longint'(bv));
    s = s >>> SHIFT;
`ifdef FC_RELU_EN
    if (s < 0) s = 0;
`endif
    if (s > hi) return hi;
    if (s < lo) return lo;
    return int'(s);
  endfunction

  typedef struct { int idx; int val; } exp_t;
  exp_t q[$];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: samples at negedge, i.e. just before the edge that acts
  bit   active = 0;
  bit   hs_valid = 0;
  int   hs_cyc = 0;
  int   done_due = -1;
  bit   rv_prev = 0;
  bit   stall_prev = 0;
  int   pd_prev = 0;
  int   pi_prev = 0;
  int   starts_seen = 0;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      q.delete();
      active = 0;
      hs_valid = 0;
      done_due = -1;
      rv_prev = 0;
      stall_prev = 0;
    end else begin
      chk("start_ready", int'(start_ready), int'(!active));
      if (start_ready || res_valid) begin
        chk("data_addr_idle", int'(data_addr), 0);
        chk("weight_addr_idle", int'(weight_addr), 0);
      end
      if (stall_prev) begin
        chk("stall_valid", int'(res_valid), 1);
        chk("stall_data", int'($signed(res_data)), pd_prev);
        chk("stall_idx", int'(res_idx), pi_prev);
      end
      if (res_valid && !rv_prev && hs_valid) begin
        chk("latency", cyc - hs_cyc, BEATS + 3);
        hs_valid = 0;
      end
      if (done || cyc == done_due)
        chk("done", int'(done), int'(cyc == done_due));
      if (res_valid && res_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          e = q.pop_front();
          chk("res_idx", int'(res_idx), e.idx);
          chk("res_data", int'($signed(res_data)), e.val);
          if (e.idx == NEU_NUM - 1) begin
            done_due = cyc + 1;
            active = 0;
          end else begin
            hs_cyc = cyc;
            hs_valid = 1;
          end
        end
      end
      if (start_valid && start_ready) begin
        for (int i = 0; i < NEU_NUM; i++) begin
          e.idx = i;
          e.val = model(i);
          q.push_back(e);
        end
        hs_cyc = cyc;
        hs_valid = 1;
        active = 1;
        starts_seen++;
      end
      stall_prev = res_valid && !res_ready;
      pd_prev = int'($signed(res_data));
      pi_prev = int'(res_idx);
      rv_prev = res_valid;
    end
  end

  // 0: always ready, 1: random, 2: held low
  int rr_mode = 0;
  always begin
    @(posedge clk);
    #1;
    case (rr_mode)
      0: res_ready = 1'b1;
      1: res_ready = 1'($urandom_range(0, 1));
      default: res_ready = 1'b0;
    endcase
  end

  task automatic fill_const(int d, int w);
    for (int k = 0; k < 2**DAW; k++)
      for (int l = 0; l < LANES; l++) dmem[k][l*DW +: DW] = DW'(d);
    for (int k = 0; k < 2**WAW; k++)
      for (int l = 0; l < LANES; l++) wmem[k][l*DW +: DW] = DW'(w);
  endtask

  task automatic fill_bias(int b0, int b1, int b2);
    for (int i = 0; i < 2**NAW; i++) bmem[i] = '0;
    bmem[0] = DW'(b0);
    bmem[1] = DW'(b1);
    bmem[2] = DW'(b2);
  endtask

  task automatic fill_random();
    for (int k = 0; k < 2**DAW; k++) dmem[k] = (LANES*DW)'($urandom);
    for (int k = 0; k < 2**WAW; k++) wmem[k] = (LANES*DW)'($urandom);
    for (int i = 0; i < 2**NAW; i++) bmem[i] = DW'($urandom);
  endtask

  task automatic start_run();
    int n = 0;
    @(posedge clk);
    #1 start_valid = 1'b1;
    @(negedge clk);
    while (!start_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("start_timeout", 1, 0);
    @(posedge clk);
    #1 start_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((active || q.size() != 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) chk("run_timeout", 1, 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_reset_outputs(string tag);
    chk({tag, "_start_ready"}, int'(start_ready), 1);
    chk({tag, "_res_valid"}, int'(res_valid), 0);
    chk({tag, "_res_data"}, int'(res_data), 0);
    chk({tag, "_res_idx"}, int'(res_idx), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_data_addr"}, int'(data_addr), 0);
    chk({tag, "_weight_addr"}, int'(weight_addr), 0);
    chk({tag, "_bias_addr"}, int'(bias_addr), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int s0;
    fill_const(0, 0);
    fill_bias(0, 0, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");

    // ones with bias {0,3,-5}: (6+0)>>>2=1, (6+3)>>>2=2, (6-5)>>>2=0
    fill_const(1, 1);
    fill_bias(0, 3, -5);
    start_run();
    wait_idle();

    // positive and negative saturation, negative pass/ReLU
    fill_const(127, 127);
    fill_bias(127, 0, -128);
    start_run();
    wait_idle();
    fill_const(127, -128);
    start_run();
    wait_idle();
    fill_const(1, -2);
    fill_bias(0, 0, 0);
    start_run();
    wait_idle();

    // output stall for several cycles
    fill_random();
    rr_mode = 2;
    start_run();
    n = 0;
    while (!res_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    rr_mode = 0;
    wait_idle();

    // reset in the middle of neuron 1, then rerun cleanly
    fill_const(1, 1);
    fill_bias(0, 3, -5);
    start_run();
    n = 0;
    while (q.size() >= NEU_NUM && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrun_reset");
    repeat (3) @(negedge clk);
    start_run();
    wait_idle();

    // start held high: second run only after first completes
    fill_random();
    s0 = starts_seen;
    @(posedge clk);
    #1 start_valid = 1'b1;
    n = 0;
    while (starts_seen < s0 + 2 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("held_start_runs", starts_seen - s0, 2);
    @(posedge clk);
    #1 start_valid = 1'b0;
    wait_idle();

    rr_mode = 1;
    for (int r = 0; r < 20; r++) begin
      fill_random();
      start_run();
      wait_idle();
    end
    rr_mode = 0;
    chk("queue_empty", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
